// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: width defaults, FSM states, port ids.
// Optional build macro MEM_TIMEOUT_EN is consumed by mem_port_arbiter.
package mem_port_arbiter_pkg;

    localparam int AW_DEF = 13;
    localparam int DW_DEF = 13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ACK
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    // One-hot {dm,if} view of a port id.
    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT_DM) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin chooser: req[0]=IF, req[1]=DM; on a tie the
// requester that was not served last wins.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = PORT_IF;
        case (req)
            2'b01:   winner = PORT_IF;
            2'b10:   winner = PORT_DM;
            2'b11:   winner = ~last;
            default: winner = PORT_IF;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one uncached Main_Memory port between instruction fetch and data access.
// Define MEM_TIMEOUT_EN to abort a BUSY phase after TIMEOUT_CYCLES without Done.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW             = AW_DEF,
    parameter int DW             = DW_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          err,
    output logic [1:0]    grant,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_write,
    output logic          mem_read,
    output logic          mem_instr,
    input  logic          mem_done
);

    localparam logic [4:0] TO_LAST = 5'(TIMEOUT_CYCLES - 1);

    arb_state_t    state_q, state_d;
    logic          owner_q;
    logic          last_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;

    logic          pick_winner;
    logic          pick_valid;
    logic          timeout;
    logic          capture;
    logic [DW-1:0] cap_data;

    rr_pick2 u_pick (
        .req    ({dm_req, if_req}),
        .last   (last_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

`ifdef MEM_TIMEOUT_EN
    logic [4:0] busy_cnt_q;
    logic       err_q;

    assign timeout = (state_q == ST_BUSY) && !mem_done && (busy_cnt_q == TO_LAST);
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    busy_cnt_q <= '0;
                    err_q      <= 1'b0;
                end
                ST_BUSY: begin
                    busy_cnt_q <= busy_cnt_q + 5'd1;
                    if (timeout) err_q <= 1'b1;
                end
                ST_ACK:  err_q <= 1'b0;
                default: ;
            endcase
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TO_LAST;
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_valid) state_d = ST_BUSY;
            ST_BUSY: if (mem_done || timeout) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A normal finish returns memory data; an abort returns all-ones.
    assign capture  = (state_q == ST_BUSY) && (mem_done || timeout);
    assign cap_data = mem_done ? mem_rdata : '1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= PORT_IF;
            last_q     <= PORT_DM;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && pick_valid) begin
                owner_q <= pick_winner;
                last_q  <= pick_winner;
                if (pick_winner == PORT_DM) begin
                    we_q    <= dm_we;
                    addr_q  <= dm_addr;
                    wdata_q <= dm_wdata;
                end else begin
                    we_q    <= 1'b0;
                    addr_q  <= if_addr;
                    wdata_q <= '0;
                end
            end
            if (capture) begin
                if (owner_q == PORT_IF)
                    if_rdata_q <= cap_data;
                else if (!we_q)
                    dm_rdata_q <= cap_data;
            end
        end
    end

    assign mem_read  = (state_q == ST_BUSY) && !we_q;
    assign mem_write = (state_q == ST_BUSY) && we_q;
    assign mem_instr = (state_q == ST_BUSY) && (owner_q == PORT_IF);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign grant     = (state_q == ST_IDLE) ? 2'b00 : port_onehot(owner_q);
    assign if_ack    = (state_q == ST_ACK) && (owner_q == PORT_IF);
    assign dm_ack    = (state_q == ST_ACK) && (owner_q == PORT_DM);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural Main_Memory model.
// Build with MEM_TIMEOUT_EN defined to exercise the abort path.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [12:0] if_addr = '0;
    logic [12:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [12:0] dm_addr = '0;
    logic [12:0] dm_wdata = '0;
    logic [12:0] dm_rdata;
    logic        dm_ack;
    logic        err;
    logic [1:0]  grant;
    logic [12:0] mem_addr;
    logic [12:0] mem_wdata;
    logic [12:0] mem_rdata;
    logic        mem_write;
    logic        mem_read;
    logic        mem_instr;
    logic        mem_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          port;
        logic [12:0] rdata;
        bit          err;
    } exp_t;
    exp_t sb[$];

    mem_port_arbiter #(.AW(13), .DW(13), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .err(err), .grant(grant),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_instr(mem_instr),
        .mem_done(mem_done)
    );

    always #5 clk = ~clk;

    // Memory model: Done after mem_wait strobe cycles unless hung.
    bit [12:0] mem_arr [8192];
    bit        mem_wr  [8192];
    int        busy_cnt = 0;
    int        mem_wait = 2;
    bit        hang = 1'b0;

    assign mem_done = (mem_read || mem_write) && !hang && (busy_cnt == mem_wait - 1);

    always_comb begin
        if (mem_wr[mem_addr]) mem_rdata = mem_arr[mem_addr];
        else if (mem_addr == 13'h004) mem_rdata = 13'h0A5;
        else mem_rdata = 13'h000;
    end

    always @(posedge clk) begin
        if (mem_read || mem_write) busy_cnt <= busy_cnt + 1;
        else busy_cnt <= 0;
        if (mem_write && mem_done) begin
            mem_arr[mem_addr] <= mem_wdata;
            mem_wr[mem_addr]  <= 1'b1;
        end
    end

    int rd_cyc = 0, wr_cyc = 0, in_cyc = 0;
    always @(negedge clk) begin
        if (!reset) begin
            rd_cyc += int'(mem_read);
            wr_cyc += int'(mem_write);
            in_cyc += int'(mem_instr);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every ack is matched against the oldest expected response.
    always @(negedge clk) begin
        if (!reset && (if_ack || dm_ack)) begin
            if (if_ack && dm_ack) check("single_ack", 32'd2, 32'd1);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got if_ack=%0b dm_ack=%0b expected none", if_ack, dm_ack);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_port", 32'(dm_ack), 32'(e.port));
                check("ack_rdata", 32'(dm_ack ? dm_rdata : if_rdata), 32'(e.rdata));
                check("ack_err", 32'(err), 32'(e.err));
                check("ack_grant", 32'(grant), e.port ? 32'd2 : 32'd1);
            end
        end
    end

    task automatic do_single(input bit dm, input bit we, input logic [12:0] addr,
                             input logic [12:0] wdata, input logic [12:0] exp_rd,
                             input bit exp_err, output int lat);
        exp_t e;
        bit   got;
        e.port = dm; e.rdata = exp_rd; e.err = exp_err;
        sb.push_back(e);
        got = 1'b0;
        if (dm) begin
            dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        lat = 1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            lat++;
            if ((dm && dm_ack) || (!dm && if_ack)) got = 1'b1;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_wait: got no ack in 60 cycles expected ack");
        end
    endtask

    task automatic run_both(input int n_acks);
        int cnt;
        cnt = 0;
        if_addr = 13'h004; dm_addr = 13'h010; dm_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        for (int i = 0; i < 200 && cnt < n_acks; i++) begin
            @(negedge clk);
            if (if_ack || dm_ack) cnt++;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        check("contention_acks", 32'(cnt), 32'(n_acks));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [12:0] exp_dm;
        exp_t        e;
        int          acks;
        exp_dm = 13'h000;

        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_strobes", 32'({mem_read, mem_write, mem_instr}), 32'd0);
        check("rst_acks", 32'({if_ack, dm_ack, err}), 32'd0);
        check("rst_rdata", 32'({if_rdata, dm_rdata}), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single fetch, Done after 2 cycles
        rd_cyc = 0; wr_cyc = 0; in_cyc = 0;
        do_single(1'b0, 1'b0, 13'h004, 13'h000, 13'h0A5, 1'b0, lat);
        check("if_latency", 32'(lat), 32'd4);
        check("if_read_cycles", 32'(rd_cyc), 32'd2);
        check("if_instr_cycles", 32'(in_cyc), 32'd2);
        check("if_write_cycles", 32'(wr_cyc), 32'd0);
        @(negedge clk);

        // Store then load back
        rd_cyc = 0; wr_cyc = 0; in_cyc = 0;
        do_single(1'b1, 1'b1, 13'h010, 13'h1F0F, exp_dm, 1'b0, lat);
        check("st_write_cycles", 32'(wr_cyc), 32'd2);
        check("st_read_cycles", 32'(rd_cyc), 32'd0);
        check("st_instr_cycles", 32'(in_cyc), 32'd0);
        @(negedge clk);
        rd_cyc = 0; wr_cyc = 0; in_cyc = 0;
        exp_dm = 13'h1F0F;
        do_single(1'b1, 1'b0, 13'h010, 13'h0000, exp_dm, 1'b0, lat);
        check("ld_read_cycles", 32'(rd_cyc), 32'd2);
        check("ld_instr_cycles", 32'(in_cyc), 32'd0);
        @(negedge clk);

        // Zero-wait memory
        mem_wait = 1;
        do_single(1'b0, 1'b0, 13'h004, 13'h000, 13'h0A5, 1'b0, lat);
        check("zero_wait_latency", 32'(lat), 32'd3);
        mem_wait = 2;
        @(negedge clk);

        // Contention from reset: IF, DM, IF, DM
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_dm_rdata", 32'(dm_rdata), 32'd0);
        e.err = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e.port  = k[0];
            e.rdata = k[0] ? 13'h1F0F : 13'h0A5;
            sb.push_back(e);
        end
        run_both(4);
        @(negedge clk);

        // Reset during a DM load
        mem_wait = 6;
        dm_we = 1'b0; dm_addr = 13'h010; dm_req = 1'b1;
        @(negedge clk);
        check("busy_grant", 32'(grant), 32'd2);
        check("busy_read", 32'(mem_read), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_strobes", 32'({mem_read, mem_write, mem_instr}), 32'd0);
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_dm_ack", 32'(dm_ack), 32'd0);
        check("midrst_dm_rdata", 32'(dm_rdata), 32'd0);
        reset = 1'b0;
        dm_req = 1'b0;
        repeat (8) @(negedge clk);
        mem_wait = 2;
        e.port = 1'b0; e.rdata = 13'h0A5; sb.push_back(e);
        e.port = 1'b1; e.rdata = 13'h1F0F; sb.push_back(e);
        run_both(2);
        @(negedge clk);

        // Memory never answers
        hang = 1'b1;
`ifdef MEM_TIMEOUT_EN
        do_single(1'b1, 1'b0, 13'h020, 13'h0000, 13'h1FFF, 1'b1, lat);
        check("timeout_latency", 32'(lat), 32'd18);
        hang = 1'b0;
        @(negedge clk);
        do_single(1'b0, 1'b0, 13'h004, 13'h000, 13'h0A5, 1'b0, lat);
`else
        acks = 0;
        dm_we = 1'b0; dm_addr = 13'h020; dm_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dm_ack || if_ack) acks++;
        end
        check("hang_no_ack", 32'(acks), 32'd0);
        check("hang_err", 32'(err), 32'd0);
        check("hang_still_read", 32'(mem_read), 32'd1);
        dm_req = 1'b0;
        hang = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
